// File: rtl/triple_sum_pkg.sv
// Shared widths and types for the triple_product_sum datapath.
// The result width leaves two headroom bits, so the three-term sum can never overflow.
package triple_sum_pkg;
    localparam int IN_W   = 8;
    localparam int PROD_W = 2 * IN_W;
    localparam int OUT_W  = 2 * IN_W + 2;

    typedef logic [IN_W-1:0]   operand_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [OUT_W-1:0]  result_t;
endpackage

// File: rtl/triple_product_sum_mult_reg.sv
// Unsigned IN_W x IN_W multiplier with a registered product.
// The product register loads only when i_en is high and otherwise keeps its value.
module mult_reg
    import triple_sum_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [IN_W-1:0]   i_a,
    input  logic [IN_W-1:0]   i_b,
    output logic [PROD_W-1:0] o_p
);
    logic [PROD_W-1:0] w_p;
    logic [PROD_W-1:0] r_p;

    assign w_p = PROD_W'(i_a) * PROD_W'(i_b);

    // NOTE: state is written with <= inside a clocked block; the asynchronous reset
    // is in the sensitivity list, so clearing does not wait for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_p <= '0;
        else if (i_en) r_p <= w_p;
    end

    assign o_p = r_p;
endmodule

// File: rtl/triple_product_sum.sv
// Two-stage pipeline that computes out = A*B + C*D + E*F on unsigned operands; latency 2, one result per cycle.
// Defining TRIPLE_SUM_ZERO_FLAG_EN adds a registered out_zero output.
module triple_product_sum
    import triple_sum_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    input  logic [IN_W-1:0]  C,
    input  logic [IN_W-1:0]  D,
    input  logic [IN_W-1:0]  E,
    input  logic [IN_W-1:0]  F,
    output logic             out_valid,
    output logic [OUT_W-1:0] out
`ifdef TRIPLE_SUM_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);
    logic [PROD_W-1:0] w_p0;
    logic [PROD_W-1:0] w_p1;
    logic [PROD_W-1:0] w_p2;
    logic [OUT_W-1:0]  w_sum;

    logic              r_valid_s1;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out;

    // Stage 1: the product registers hold their value while in_valid is low.
    mult_reg u_mult_ab (.clk(clk), .rst(rst), .i_en(in_valid), .i_a(A), .i_b(B), .o_p(w_p0));
    mult_reg u_mult_cd (.clk(clk), .rst(rst), .i_en(in_valid), .i_a(C), .i_b(D), .o_p(w_p1));
    mult_reg u_mult_ef (.clk(clk), .rst(rst), .i_en(in_valid), .i_a(E), .i_b(F), .o_p(w_p2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_valid_s1 <= 1'b0;
        else     r_valid_s1 <= in_valid;
    end

    assign w_sum = result_t'(w_p0) + result_t'(w_p1) + result_t'(w_p2);

    // Stage 2: out only moves on a valid result, so it holds through idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_out_valid <= r_valid_s1;
            if (r_valid_s1) r_out <= w_sum;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;

`ifdef TRIPLE_SUM_ZERO_FLAG_EN
    logic r_out_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_out_zero <= 1'b0;
        else     r_out_zero <= r_valid_s1 && (w_sum == '0);
    end

    assign out_zero = r_out_zero;
`endif
endmodule

// File: tb/tb_triple_product_sum.sv
// Testbench for triple_product_sum: a scoreboard of expected results, each stamped with the clock edge it is due on.
// It drives a vector table, reset corner cases and a random back-to-back burst.
module tb_triple_product_sum;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a, b, c, d, e, f;
    logic        out_valid;
    logic [17:0] out;
`ifdef TRIPLE_SUM_ZERO_FLAG_EN
    logic        out_zero;
`endif

    triple_product_sum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(a), .B(b), .C(c), .D(d), .E(e), .F(f),
        .out_valid(out_valid), .out(out)
`ifdef TRIPLE_SUM_ZERO_FLAG_EN
        , .out_zero(out_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  a, b, c, d, e, f;
        logic [17:0] exp;
    } vec_t;

    typedef struct {
        logic [17:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[9];
    int          total = 0;
    int          bad = 0;
    int          edge_cnt = 0;
    logic [17:0] last_out = '0;

    function automatic logic [17:0] model(input logic [7:0] pa, pb, pc, pd, pe, pf);
        int unsigned s;
        s = int'(pa) * int'(pb) + int'(pc) * int'(pd) + int'(pe) * int'(pf);
        return s[17:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", name, edge_cnt, act, exp);
        end
    endtask

    // Inputs are applied 1 time unit after an edge and take effect at the next edge.
    task automatic drive(input logic v, input logic [7:0] pa, pb, pc, pd, pe, pf, input logic [17:0] exp);
        exp_t item;
        in_valid = v;
        a = pa; b = pb; c = pc; d = pd; e = pe; f = pf;
        if (v && !rst) begin
            item.res = exp;
            item.due = edge_cnt + 2;
            sb.push_back(item);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
        if (sb.size() > 0 && sb[0].due == edge_cnt) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out", 32'(out), 32'(sb[0].res));
`ifdef TRIPLE_SUM_ZERO_FLAG_EN
            check("out_zero", 32'(out_zero), 32'(sb[0].res == '0));
`endif
            last_out = sb[0].res;
            void'(sb.pop_front());
        end else begin
            check("idle_valid", 32'(out_valid), 32'd0);
            check("hold_out", 32'(out), 32'(last_out));
`ifdef TRIPLE_SUM_ZERO_FLAG_EN
            check("idle_zero", 32'(out_zero), 32'd0);
`endif
        end
    endtask

    task automatic drive_rand(input logic v);
        logic [7:0] r[6];
        for (int i = 0; i < 6; i++) r[i] = 8'($urandom_range(0, 255));
        drive(v, r[0], r[1], r[2], r[3], r[4], r[5], model(r[0], r[1], r[2], r[3], r[4], r[5]));
    endtask

    initial begin
        tbl[0] = '{1'b1,  52, 125, 100,  98,  20,  15, 18'd16600};
        tbl[1] = '{1'b1,  48, 201,  66,  54,  99,  52, 18'd18360};
        tbl[2] = '{1'b1,  86, 114, 126,  88, 123,  81, 18'd30855};
        tbl[3] = '{1'b1, 255, 255, 255, 255, 255, 255, 18'd195075};
        tbl[4] = '{1'b1,   0,   0,   0,   0,   0,   0, 18'd0};
        tbl[5] = '{1'b1,  52, 125, 100,  98,  20,  15, 18'd16600};
        tbl[6] = '{1'b0,  99,  99,  99,  99,  99,  99, 18'd0};
        tbl[7] = '{1'b1,  48, 201,  66,  54,  99,  52, 18'd18360};
        tbl[8] = '{1'b0,   0,   0,   0,   0,   0,   0, 18'd0};

        // Reset held with live operands: outputs stay cleared.
        rst = 1'b1;
        drive_rand(1'b1);
        #2;
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            step();
        end
        rst = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0, 18'd0);
        step();

        // Table: single, back-to-back, extremes, then the 1,0,1 valid pattern.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].e, tbl[i].f, tbl[i].exp);
            step();
        end
        for (int i = 0; i < 3; i++) step();

        // A valid input in stage 1 when reset hits must never appear at the output.
        drive(1'b1, 86, 114, 126, 88, 123, 81, 18'd30855);
        step();
        rst = 1'b1;
        #1;
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        sb.delete();
        last_out = '0;
        drive_rand(1'b1);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0, 18'd0);
        step();
        drive(1'b1, 52, 125, 100, 98, 20, 15, 18'd16600);
        step();
        drive(1'b0, 1, 1, 1, 1, 1, 1, 18'd0);
        step();
        step();

        // Random burst with occasional gaps.
        for (int i = 0; i < 40; i++) begin
            drive_rand(($urandom_range(0, 3) != 0));
            step();
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0, 18'd0);
        for (int i = 0; i < 4; i++) step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
